ppwm_multi: RTL and testbench

Parametrised multi-channel PWM generator sharing one prescaled period counter across CHANNELS outputs, with edge-aligned or center-aligned counting and glitch-free shadowed reconfiguration. It sits between the pad-level PWM outputs and a simple register write port driven by the top-level wrapper. Period, prescale, mode and per-channel duty are all runtime-programmable.

---
 rtl/ppwm_pkg.sv | 12 +
 rtl/ppwm_channel.sv | 42 ++++
 rtl/ppwm_multi.sv | 119 +++++++++++
 tb/tb_ppwm_multi.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/ppwm_pkg.sv
// rtl/ppwm_pkg.sv - shared constants and types for the multi-channel PWM generator
package ppwm_pkg;

  localparam int ADDR_PERIOD   = 0;
  localparam int ADDR_PRESCALE = 1;
  localparam int ADDR_CTRL     = 2;
  localparam int ADDR_DUTY0    = 3;

  typedef enum logic {MODE_EDGE = 1'b0, MODE_CENTER = 1'b1} ppwm_mode_e;
  typedef enum logic {DIR_UP = 1'b0, DIR_DOWN = 1'b1} ppwm_dir_e;

endpackage

// File: rtl/ppwm_channel.sv
// rtl/ppwm_channel.sv - one PWM channel: shadowed duty register and registered compare output
module ppwm_channel
  import ppwm_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int ADDR_W = 3,
  parameter int INDEX  = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              load,
  input  logic              cfg_we,
  input  logic [ADDR_W-1:0] cfg_addr,
  input  logic [WIDTH-1:0]  cfg_wdata,
  input  logic [WIDTH-1:0]  cnt,
  output logic              pwm
);

  localparam logic [ADDR_W-1:0] DUTY_ADDR = ADDR_W'(ADDR_DUTY0 + INDEX);

  logic [WIDTH-1:0] duty_sh;
  logic [WIDTH-1:0] duty_act;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      duty_sh  <= '0;
      duty_act <= '0;
      pwm      <= 1'b0;
    end else begin
      if (cfg_we && (cfg_addr == DUTY_ADDR)) begin
        duty_sh <= cfg_wdata;
      end
      // Active duty takes the pre-write shadow value, so a write on a boundary waits a period
      if (load) begin
        duty_act <= duty_sh;
      end
      pwm <= en && (cnt < duty_act);
    end
  end

endmodule

// File: rtl/ppwm_multi.sv
// rtl/ppwm_multi.sv - multi-channel PWM with shared prescaled edge/center counter and shadowed config
module ppwm_multi
  import ppwm_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4,
  parameter int ADDR_W   = $clog2(CHANNELS + 3)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                cfg_we,
  input  logic [ADDR_W-1:0]   cfg_addr,
  input  logic [WIDTH-1:0]    cfg_wdata,
  output logic [CHANNELS-1:0] pwm_out,
  output logic [WIDTH-1:0]    cnt_out,
  output logic                period_tick
);

  localparam logic [WIDTH-1:0]  ONE           = WIDTH'(1);
  localparam logic [ADDR_W-1:0] A_PERIOD      = ADDR_W'(ADDR_PERIOD);
  localparam logic [ADDR_W-1:0] A_PRESCALE    = ADDR_W'(ADDR_PRESCALE);
  localparam logic [ADDR_W-1:0] A_CTRL        = ADDR_W'(ADDR_CTRL);

  logic [WIDTH-1:0] period_sh, period_act;
  logic [WIDTH-1:0] prescale_sh, prescale_act;
  ppwm_mode_e       mode_sh, mode_act;
  logic [WIDTH-1:0] psc, cnt, cnt_nxt;
  ppwm_dir_e        dir, dir_nxt;
  logic             tick, boundary, load;

  always_comb begin
    tick    = en && (psc == prescale_act);
    cnt_nxt = cnt;
    dir_nxt = dir;
    if (tick) begin
      if (mode_act == MODE_EDGE) begin
        cnt_nxt = (cnt == period_act) ? '0 : cnt + ONE;
        dir_nxt = DIR_UP;
      end else if (dir == DIR_UP) begin
        if (cnt == period_act) begin
          cnt_nxt = (period_act == '0) ? '0 : cnt - ONE;
          dir_nxt = DIR_DOWN;
        end else begin
          cnt_nxt = cnt + ONE;
        end
      end else begin
        cnt_nxt = cnt - ONE;
      end
      if (cnt_nxt == '0) begin
        dir_nxt = DIR_UP;
      end
    end
    boundary = tick && (cnt_nxt == '0);
    load     = boundary || !en;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      period_sh    <= '1;
      period_act   <= '1;
      prescale_sh  <= '0;
      prescale_act <= '0;
      mode_sh      <= MODE_EDGE;
      mode_act     <= MODE_EDGE;
      psc          <= '0;
      cnt          <= '0;
      dir          <= DIR_UP;
      period_tick  <= 1'b0;
    end else begin
      if (cfg_we) begin
        if (cfg_addr == A_PERIOD) begin
          period_sh <= cfg_wdata;
        end else if (cfg_addr == A_PRESCALE) begin
          prescale_sh <= cfg_wdata;
        end else if (cfg_addr == A_CTRL) begin
          mode_sh <= cfg_wdata[0] ? MODE_CENTER : MODE_EDGE;
        end
      end
      if (load) begin
        period_act   <= period_sh;
        prescale_act <= prescale_sh;
        mode_act     <= mode_sh;
      end
      if (!en) begin
        psc         <= '0;
        cnt         <= '0;
        dir         <= DIR_UP;
        period_tick <= 1'b0;
      end else begin
        psc         <= tick ? '0 : psc + ONE;
        cnt         <= cnt_nxt;
        dir         <= load ? DIR_UP : dir_nxt;
        period_tick <= boundary;
      end
    end
  end

  assign cnt_out = cnt;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    ppwm_channel #(
      .WIDTH  (WIDTH),
      .ADDR_W (ADDR_W),
      .INDEX  (i)
    ) u_ch (
      .clk       (clk),
      .rst       (rst),
      .en        (en),
      .load      (load),
      .cfg_we    (cfg_we),
      .cfg_addr  (cfg_addr),
      .cfg_wdata (cfg_wdata),
      .cnt       (cnt),
      .pwm       (pwm_out[i])
    );
  end

endmodule

// File: tb/tb_ppwm_multi.sv
// tb/tb_ppwm_multi.sv - directed table-driven bench for ppwm_multi
module tb_ppwm_multi;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       cfg_we;
  logic [2:0] cfg_addr;
  logic [7:0] cfg_wdata;
  logic [3:0] pwm_out;
  logic [7:0] cnt_out;
  logic       period_tick;

  int n_checks = 0;
  int n_fail   = 0;

  ppwm_multi dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .cfg_we      (cfg_we),
    .cfg_addr    (cfg_addr),
    .cfg_wdata   (cfg_wdata),
    .pwm_out     (pwm_out),
    .cnt_out     (cnt_out),
    .period_tick (period_tick)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       en;
    logic       we;
    logic [2:0] addr;
    logic [7:0] data;
    logic [7:0] cnt;
    logic       tick;
    logic [3:0] pwm;
  } vec_t;

  vec_t tbl [0:19];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [2:0] a, input logic [7:0] d);
    cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
    step();
    cfg_we = 1'b0;
  endtask

  // center-aligned count for P=3, k ticks after start
  function automatic int ctr(input int k);
    int m;
    m = k % 6;
    return (m <= 3) ? m : 6 - m;
  endfunction

  initial begin
    rst = 1'b1; en = 1'b0; cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0;

    tbl[0]  = '{1'b0, 1'b1, 3'd0, 8'd9,  8'd0, 1'b0, 4'b0000};
    tbl[1]  = '{1'b0, 1'b1, 3'd1, 8'd0,  8'd0, 1'b0, 4'b0000};
    tbl[2]  = '{1'b0, 1'b1, 3'd2, 8'd2,  8'd0, 1'b0, 4'b0000};
    tbl[3]  = '{1'b0, 1'b1, 3'd3, 8'd3,  8'd0, 1'b0, 4'b0000};
    tbl[4]  = '{1'b0, 1'b1, 3'd4, 8'd0,  8'd0, 1'b0, 4'b0000};
    tbl[5]  = '{1'b0, 1'b1, 3'd5, 8'd10, 8'd0, 1'b0, 4'b0000};
    tbl[6]  = '{1'b0, 1'b1, 3'd6, 8'd5,  8'd0, 1'b0, 4'b0000};
    tbl[7]  = '{1'b0, 1'b1, 3'd7, 8'd1,  8'd0, 1'b0, 4'b0000};
    tbl[8]  = '{1'b1, 1'b0, 3'd0, 8'd0,  8'd1, 1'b0, 4'b1101};
    tbl[9]  = '{1'b1, 1'b0, 3'd0, 8'd0,  8'd2, 1'b0, 4'b1101};
    tbl[10] = '{1'b1, 1'b0, 3'd0, 8'd0,  8'd3, 1'b0, 4'b1101};
    tbl[11] = '{1'b1, 1'b0, 3'd0, 8'd0,  8'd4, 1'b0, 4'b1100};
    tbl[12] = '{1'b1, 1'b0, 3'd0, 8'd0,  8'd5, 1'b0, 4'b1100};
    tbl[13] = '{1'b1, 1'b0, 3'd0, 8'd0,  8'd6, 1'b0, 4'b0100};
    tbl[14] = '{1'b1, 1'b0, 3'd0, 8'd0,  8'd7, 1'b0, 4'b0100};
    tbl[15] = '{1'b1, 1'b0, 3'd0, 8'd0,  8'd8, 1'b0, 4'b0100};
    tbl[16] = '{1'b1, 1'b0, 3'd0, 8'd0,  8'd9, 1'b0, 4'b0100};
    tbl[17] = '{1'b1, 1'b0, 3'd0, 8'd0,  8'd0, 1'b1, 4'b0100};
    tbl[18] = '{1'b1, 1'b0, 3'd0, 8'd0,  8'd1, 1'b0, 4'b1101};
    tbl[19] = '{1'b1, 1'b0, 3'd0, 8'd0,  8'd2, 1'b0, 4'b1101};

    // reset state
    step(); step();
    check("reset_cnt", 32'(cnt_out), 32'd0);
    check("reset_pwm", 32'(pwm_out), 32'd0);
    check("reset_tick", 32'(period_tick), 32'd0);
    rst = 1'b0; en = 1'b1;

    // free-running 8-bit counter with reset configuration
    for (int k = 1; k <= 512; k++) begin
      step();
      check("free_cnt", 32'(cnt_out), 32'(k % 256));
      check("free_tick", 32'(period_tick), 32'(k % 256 == 0));
      check("free_pwm", 32'(pwm_out), 32'd0);
    end

    // table: configuration writes while disabled, then edge-mode run with P=9
    for (int j = 0; j < 20; j++) begin
      en = tbl[j].en; cfg_we = tbl[j].we; cfg_addr = tbl[j].addr; cfg_wdata = tbl[j].data;
      step();
      check("tbl_cnt", 32'(cnt_out), 32'(tbl[j].cnt));
      check("tbl_tick", 32'(period_tick), 32'(tbl[j].tick));
      check("tbl_pwm", 32'(pwm_out), 32'(tbl[j].pwm));
    end
    cfg_we = 1'b0;

    // mid-period duty write (3->8), then a write on the boundary cycle (8->1)
    for (int k = 13; k <= 50; k++) begin
      int d;
      cfg_we = (k == 13) || (k == 30);
      cfg_addr = 3'd3;
      cfg_wdata = (k == 13) ? 8'd8 : 8'd1;
      step();
      d = (k >= 41) ? 1 : ((k >= 21) ? 8 : 3);
      check("dutyw_cnt", 32'(cnt_out), 32'(k % 10));
      check("dutyw_tick", 32'(period_tick), 32'(k % 10 == 0));
      check("dutyw_pwm0", 32'(pwm_out[0]), 32'(((k - 1) % 10) < d));
    end
    cfg_we = 1'b0;

    // prescaler: PRESCALE=2, PERIOD=4
    en = 1'b0;
    step();
    wr(3'd1, 8'd2);
    wr(3'd0, 8'd4);
    step();
    en = 1'b1;
    for (int k = 1; k <= 45; k++) begin
      step();
      check("psc_cnt", 32'(cnt_out), 32'((k / 3) % 5));
      check("psc_tick", 32'(period_tick), 32'(k % 15 == 0));
      check("psc_pwm0", 32'(pwm_out[0]), 32'(((k - 1) / 3) % 5 == 0));
    end

    // center mode: PRESCALE=0, CTRL=1, PERIOD=3, DUTY0=2
    en = 1'b0;
    step();
    wr(3'd1, 8'd0);
    wr(3'd2, 8'd1);
    wr(3'd0, 8'd3);
    wr(3'd3, 8'd2);
    step();
    en = 1'b1;
    for (int k = 1; k <= 24; k++) begin
      step();
      check("ctr_cnt", 32'(cnt_out), 32'(ctr(k)));
      check("ctr_tick", 32'(period_tick), 32'(k % 6 == 0));
      check("ctr_pwm", 32'(pwm_out), 32'({2'b11, 1'b0, ctr(k - 1) < 2}));
    end

    // asynchronous reset mid-period with pwm_out[0] high
    step();
    check("pre_rst_pwm0", 32'(pwm_out[0]), 32'd1);
    check("pre_rst_cnt", 32'(cnt_out), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("async_rst_pwm", 32'(pwm_out), 32'd0);
    check("async_rst_cnt", 32'(cnt_out), 32'd0);
    check("async_rst_tick", 32'(period_tick), 32'd0);
    step();
    rst = 1'b0;
    for (int k = 1; k <= 260; k++) begin
      step();
      check("post_rst_cnt", 32'(cnt_out), 32'(k % 256));
      check("post_rst_tick", 32'(period_tick), 32'(k % 256 == 0));
      check("post_rst_pwm", 32'(pwm_out), 32'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
